ifetch_queue: RTL and testbench

//  Instruction-fetch front end that sits directly upstream of the IF/ID register.

---
 rtl/ifetch_queue_if.sv | 25 ++
 rtl/ifetch_queue.sv | 141 ++++++++++++++
 tb/tb_ifetch_queue.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, NPC redirect logic and IF/ID.
// The master modport is the fetch queue's view; slave is the surrounding pipeline's view.
interface ifetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_inst, fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_inst, fetch_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a variable-latency
// instruction memory and buffers {pc, inst} pairs in a prefetch FIFO ahead of IF/ID.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic           clock,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   addr_q;
    logic          redirect;
    logic          ack;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    assign redirect       = bus.redirect_valid;
    assign ack            = bus.imem_ack;
    assign unused_pc_bits = ^bus.redirect_pc[1:0];

    // A redirect cycle never transfers, so a stale head cannot slip out while flushing.
    assign bus.out_valid = (count != '0) && !redirect;
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = (state == REQ) && ack && !redirect;

    assign bus.imem_req  = (state != IDLE);
    assign bus.imem_addr = addr_q;
    assign bus.fetch_pc  = fetch_pc_q;
    assign bus.out_pc    = pc_mem[rd_ptr];
    assign bus.out_inst  = inst_mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_comb begin
        fetch_pc_next = fetch_pc_q;
        if (redirect) begin
            fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_next = fetch_pc_q + 32'd4;
        end
    end

    // REQ reserves its FIFO slot, so an idle FSM only needs count < DEPTH to start a read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!redirect && (count < FULL)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_next = ack ? IDLE : DROP;
                end else if (ack) begin
                    state_next = (count_next < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state      <= state_next;
            count      <= count_next;
            fetch_pc_q <= fetch_pc_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            // The address only moves between reads; DROP keeps it for the outstanding one.
            if ((state == IDLE) || push) begin
                addr_q <= fetch_pc_next;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= addr_q;
            inst_mem[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised scoreboard bench for ifetch_queue: a memory responder with selectable latency
// feeds the DUT, and a monitor checks every IF/ID transfer against the expected fetch stream.
module tb_ifetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clock;
    logic reset;

    ifetch_queue_if bus ();

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          xfer_count = 0;
    int          ack_count  = 0;
    int          mem_mode   = 0;
    int          fixed_lat  = 0;
    bit          late_ack   = 0;
    exp_t        exp_q [$];
    logic [31:0] req_log [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected IF/ID stream after a restart: consecutive words from the aligned start address.
    task automatic start_stream(input logic [31:0] start);
        logic [31:0] a;
        a = {start[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back('{pc: a, inst: inst_of(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit ready);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.out_ready      = ready;
        if (redir) begin
            start_stream(rpc);
        end
    endtask

    task automatic do_redirect(input logic [31:0] rpc);
        applyStimulus(1'b1, rpc, bus.out_ready);
        tick(1);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start_stream(RESET_PC);
        ack_count = 0;
        req_log.delete();
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    // Instruction memory: one read at a time, latency chosen when the request is first seen.
    always begin : responder
        bit          busy;
        int          remaining;
        logic [31:0] cur_addr;
        @(posedge clock);
        #1;
        if (late_ack) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
            late_ack       = 1'b0;
            busy           = 1'b0;
        end else if (!reset) begin
            bus.imem_ack = 1'b0;
            busy         = 1'b0;
        end else begin
            if (busy) begin
                checkOutput("req_held", 32'(bus.imem_req), 32'd1);
                checkOutput("addr_held", bus.imem_addr, cur_addr);
            end else if (bus.imem_req) begin
                busy     = 1'b1;
                cur_addr = bus.imem_addr;
                req_log.push_back(cur_addr);
                case (mem_mode)
                    0:       remaining = 0;
                    1:       remaining = $urandom_range(0, 3);
                    default: remaining = fixed_lat;
                endcase
            end
            if (busy && (remaining == 0)) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = inst_of(cur_addr);
                busy           = 1'b0;
                ack_count++;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                if (busy) begin
                    remaining--;
                end
            end
        end
    end

    // Scoreboard monitor: pops one expected entry per observed transfer.
    always begin : monitor
        bit          prev_hold;
        logic [31:0] prev_pc;
        logic [31:0] prev_inst;
        exp_t        e;
        @(negedge clock);
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                checkOutput("no_valid_on_redirect", 32'(bus.out_valid), 32'd0);
            end
            if (prev_hold && bus.out_valid) begin
                checkOutput("head_pc_stable", bus.out_pc, prev_pc);
                checkOutput("head_inst_stable", bus.out_inst, prev_inst);
            end
            if (bus.out_valid && bus.out_ready) begin
                xfer_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", bus.out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_pc", bus.out_pc, e.pc);
                    checkOutput("out_inst", bus.out_inst, e.inst);
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_pc   = bus.out_pc;
            prev_inst = bus.out_inst;
        end
    end

    initial begin : main
        int          x0;
        logic [31:0] rpc;
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        start_stream(RESET_PC);
        tick(2);

        $display("[TB] reset values");
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
        checkOutput("rst_fetch_pc", bus.fetch_pc, RESET_PC);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_pc", bus.out_pc, 32'h0);
        checkOutput("rst_out_inst", bus.out_inst, 32'h0);
        reset = 1'b1;
        checkOutput("release_req_low", 32'(bus.imem_req), 32'd0);
        tick(1);
        checkOutput("first_req", 32'(bus.imem_req), 32'd1);
        checkOutput("first_addr", bus.imem_addr, RESET_PC);

        $display("[TB] zero-wait streaming");
        for (int i = 0; i < 10 && xfer_count == 0; i++) tick(1);
        checkOutput("stream_started", 32'(xfer_count > 0), 32'd1);
        x0 = xfer_count;
        tick(20);
        checkOutput("stream_no_gaps", 32'(xfer_count - x0), 32'd20);

        $display("[TB] fill to full with out_ready low");
        bus.out_ready = 1'b0;
        mem_mode = 0;
        do_reset();
        tick(12);
        checkOutput("full_ack_count", 32'(ack_count), 32'd4);
        checkOutput("full_req_low", 32'(bus.imem_req), 32'd0);
        checkOutput("full_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("full_head_pc", bus.out_pc, RESET_PC);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        tick(5);
        checkOutput("refill_ack_count", 32'(ack_count), 32'd5);
        checkOutput("refill_addr", req_log[$], 32'h0000_3010);
        checkOutput("refill_req_low", 32'(bus.imem_req), 32'd0);
        checkOutput("refill_fetch_pc", bus.fetch_pc, 32'h0000_3014);

        $display("[TB] redirect with read outstanding");
        bus.out_ready = 1'b1;
        mem_mode = 2;
        fixed_lat = 3;
        do_reset();
        for (int i = 0; i < 40 && !(bus.imem_req && bus.imem_addr == 32'h0000_300C); i++) tick(1);
        checkOutput("wait_req_300c", bus.imem_addr, 32'h0000_300C);
        do_redirect(32'h0000_3107);
        req_log.delete();
        checkOutput("drop_req_held", 32'(bus.imem_req), 32'd1);
        checkOutput("drop_addr_held", bus.imem_addr, 32'h0000_300C);
        checkOutput("drop_fetch_pc", bus.fetch_pc, 32'h0000_3104);
        x0 = xfer_count;
        tick(15);
        checkOutput("post_drop_req_seen", 32'(req_log.size() > 0), 32'd1);
        if (req_log.size() > 0) checkOutput("post_drop_addr", req_log[0], 32'h0000_3104);
        checkOutput("post_drop_progress", 32'(xfer_count > x0), 32'd1);

        $display("[TB] redirect coincident with ack and out_ready");
        mem_mode = 0;
        tick(8);
        checkOutput("steady_req", 32'(bus.imem_req), 32'd1);
        applyStimulus(1'b1, 32'h0000_5000, 1'b1);
        #1;
        checkOutput("redir_cycle_valid", 32'(bus.out_valid), 32'd0);
        tick(1);
        bus.redirect_valid = 1'b0;
        checkOutput("after_redir_empty", 32'(bus.out_valid), 32'd0);
        checkOutput("after_redir_idle", 32'(bus.imem_req), 32'd0);
        checkOutput("after_redir_fetch_pc", bus.fetch_pc, 32'h0000_5000);
        x0 = xfer_count;
        tick(6);
        checkOutput("after_redir_progress", 32'(xfer_count > x0), 32'd1);

        $display("[TB] address wrap");
        do_redirect(32'hFFFF_FFFC);
        x0 = xfer_count;
        tick(10);
        checkOutput("wrap_progress", 32'(xfer_count - x0 >= 3), 32'd1);

        $display("[TB] asynchronous reset mid-read");
        bus.out_ready = 1'b0;
        mem_mode = 2;
        fixed_lat = 2;
        do_reset();
        for (int i = 0; i < 30 && !(ack_count == 2 && responder.busy); i++) begin
            tick(1);
            #2;
        end
        checkOutput("wait_two_pushes", 32'(ack_count), 32'd2);
        checkOutput("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("async_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("async_imem_addr", bus.imem_addr, RESET_PC);
        checkOutput("async_fetch_pc", bus.fetch_pc, RESET_PC);
        checkOutput("async_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_out_pc", bus.out_pc, 32'h0);
        checkOutput("async_out_inst", bus.out_inst, 32'h0);
        late_ack = 1'b1;
        tick(1);
        start_stream(RESET_PC);
        ack_count = 0;
        reset = 1'b1;
        tick(1);
        checkOutput("restart_req", 32'(bus.imem_req), 32'd1);
        checkOutput("restart_addr", bus.imem_addr, RESET_PC);
        checkOutput("restart_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        x0 = xfer_count;
        tick(15);
        checkOutput("restart_progress", 32'(xfer_count - x0 >= 2), 32'd1);

        $display("[TB] randomised traffic");
        mem_mode = 1;
        x0 = xfer_count;
        for (int i = 0; i < 2000; i++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) begin
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
                do_redirect(rpc);
            end else begin
                tick(1);
            end
        end
        checkOutput("random_progress", 32'(xfer_count - x0 > 200), 32'd1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
